dp_grant_seq: RTL and testbench
===============================

# dp_grant_seq

Grant sequencer at the consuming end of the dual-priority encoder's code interface. Accepts a pair of 1-based request codes (first = highest priority, second = next), decodes each to a one-hot grant over the 12 request lines, and serves them in order. Each grant is held until the grantee signals completion or a timeout expires. Sits between the dual-priority encoder output and the shared resource's grantees.

## Interface
- N_REQ, 12, number of request/grant lines; codes are 1..N_REQ, 0 = none
- CODE_W, 4, code width; must hold N_REQ
- TIMEOUT, 16, maximum cycles a grant is held without `done`; legal range 2..255
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  code pair valid
- in_ready  out  1  sequencer can accept a pair; high only in IDLE
- first  in  CODE_W  highest-priority code, 0 = no request
- second  in  CODE_W  second-priority code, 0 = none; legal only if < first
- grant  out  N_REQ  one-hot grant (bit k-1 for code k), or all-zero
- grant_code  out  CODE_W  code currently granted, 0 when idle
- done  in  1  grantee finished; sampled only while a grant is active
- busy  out  1  high in GNT1/GNT2
- timeout  out  1  one-cycle pulse when a grant is dropped by timeout
- err  out  1  one-cycle pulse on acceptance of an illegal pair

## Operation
- States: IDLE, GNT1, GNT2. Reset forces IDLE, clears the hold counter and the captured codes.
- IDLE: `in_ready`=1. On `in_valid`, capture first/second and validate:
  - first > N_REQ counts as illegal, with first treated as 0.
  - second > N_REQ, or second != 0 with second >= first, counts as illegal, with second treated as 0.
  - Any illegal field pulses `err` on the cycle after acceptance.
  - If the effective first = 0, the pair is consumed and the sequencer stays in IDLE. A nonzero second is discarded and pulses `err`.
  - Otherwise go to GNT1.
- GNT1: `grant`=onehot(first), `grant_code`=first, `busy`=1. The hold counter increments each cycle starting at 0. Exit on `done`=1 or when the counter reaches TIMEOUT-1.
  - If exit is by timeout without `done`, pulse `timeout`.
  - Go to GNT2 if the effective second != 0, else go to IDLE. The counter clears on exit.
- GNT2: same behaviour as GNT1, using second. Always returns to IDLE.
- `done` in IDLE is ignored. `done` in the same cycle the counter reaches TIMEOUT-1 counts as done, so no `timeout` pulse.
- `in_valid` outside IDLE is ignored. The upstream holds the pair until it sees `in_ready`.

## Timing
- All outputs except `in_ready` are registered. `in_ready` is decoded from the state register.
- Reset values: grant=0, grant_code=0, busy=0, timeout=0, err=0, in_ready=1 from the cycle after reset deasserts.
- Acceptance happens at edge T (in_valid & in_ready). `grant` is valid in cycle T+1.
- `done` is sampled at edge E. The first grant drops and the second grant is asserted in cycle E+1, with no gap cycle.
- The state returns to IDLE in the cycle after the last grant ends. Grants are therefore zero for at least one cycle between pairs.
- Maximum hold per grant is TIMEOUT cycles. Worst-case pair occupancy is 2·TIMEOUT+1 cycles including the IDLE cycle.
- Reset mid-grant: `grant` is 0 in the cycle after the reset edge. There is no `timeout` or `err` pulse. The captured pair is lost.

## Structure
- Shared package holds N_REQ, CODE_W, the state encoding (IDLE=0, GNT1=1, GNT2=2) and the code-legality rule. The encoder and this block use the same package.
- One sub-module, `dp_code_dec`: combinational CODE_W to N_REQ one-hot decoder that outputs zero for code 0 or code > N_REQ. It is instantiated once and driven by the active code.
- The hold counter is $clog2(TIMEOUT) bits wide.

## Test plan
- Pair (first=12, second=5), `done` on the 3rd grant cycle of each grant:
  - grant = 0x800 for 3 cycles, then 0x010 for 3 cycles, then 0.
  - grant_code 12 then 5; timeout and err stay 0.
- Pair (first=1, second=0), `done` never asserted, TIMEOUT=16:
  - grant = 0x001 for exactly 16 cycles.
  - timeout pulses once, in the cycle after the last grant cycle.
  - Sequencer returns to IDLE.
- Illegal pairs:
  - (first=7, second=9): err pulses; only grant 0x040 is served.
  - (first=14, second=3): err pulses; no grant.
  - (first=0, second=0): no grant, no err.
- `done` coincident with the TIMEOUT-1 count: no timeout pulse; the sequencer advances to second normally.
- `in_valid` held high with a new pair during GNT2: the pair is not accepted until IDLE; in_ready=0 for the whole busy period.
- Reset asserted in GNT1 with pair (10, 4):
  - grant=0 and busy=0 in the next cycle; no pulses.
  - A following pair (3, 2) is served correctly.

Source files
------------

// File: rtl/dp_grant_seq_pkg.sv
// rtl/dp_grant_seq_pkg.sv - shared sizing, state encoding and code-pair legality rule
// Used by both the dual-priority encoder and the grant sequencer.
package dp_grant_seq_pkg;

  localparam int N_REQ  = 12;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] first;
    logic [CODE_W-1:0] second;
    logic              err;
  } pair_t;

  function automatic logic code_in_range(input logic [CODE_W-1:0] code);
    return code <= CODE_W'(N_REQ);
  endfunction

  // Illegal fields collapse to 0; a second code with no first is discarded and flagged.
  function automatic pair_t check_pair(input logic [CODE_W-1:0] first,
                                       input logic [CODE_W-1:0] second);
    pair_t p;
    logic  first_bad;
    logic  second_bad;
    first_bad  = !code_in_range(first);
    second_bad = !code_in_range(second) || ((second != '0) && (second >= first));
    p.first    = first_bad ? '0 : first;
    p.second   = (second_bad || (p.first == '0)) ? '0 : second;
    p.err      = first_bad || second_bad || ((p.first == '0) && (second != '0));
    return p;
  endfunction

endpackage

// File: rtl/dp_grant_seq_code_dec.sv
// rtl/dp_grant_seq_code_dec.sv - 1-based code to one-hot grant decoder
// Codes 0 and above N_REQ decode to all-zero.
module dp_code_dec
  import dp_grant_seq_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [N_REQ-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      onehot[k] = (code == CODE_W'(k + 1));
    end
  end

endmodule

// File: rtl/dp_grant_seq.sv
// rtl/dp_grant_seq.sv - serves a captured code pair as back-to-back held grants
// Each grant ends on done or after TIMEOUT cycles; outputs are registered.
module dp_grant_seq
  import dp_grant_seq_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] first,
  input  logic [CODE_W-1:0] second,
  output logic [N_REQ-1:0]  grant,
  output logic [CODE_W-1:0] grant_code,
  input  logic              done,
  output logic              busy,
  output logic              timeout,
  output logic              err
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [CODE_W-1:0] code1;
  logic [CODE_W-1:0] code2;
  logic [CNT_W-1:0]  cnt;

  pair_t             pair;
  logic              at_limit;
  logic              hold_end;
  logic [CODE_W-1:0] next_code;
  logic [N_REQ-1:0]  next_grant;

  assign in_ready = (state == IDLE);
  assign pair     = check_pair(first, second);
  assign at_limit = (cnt == CNT_LAST);
  assign hold_end = done || at_limit;

  // Code that will be granted in the next cycle; the registered grant follows it.
  always_comb begin
    next_code = '0;
    case (state)
      IDLE:    next_code = in_valid ? pair.first : '0;
      GNT1:    next_code = hold_end ? code2 : code1;
      GNT2:    next_code = hold_end ? '0 : code2;
      default: next_code = '0;
    endcase
  end

  dp_code_dec u_dec (
    .code   (next_code),
    .onehot (next_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      code1      <= '0;
      code2      <= '0;
      cnt        <= '0;
      grant      <= '0;
      grant_code <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      err        <= 1'b0;
    end else begin
      grant      <= next_grant;
      grant_code <= next_code;
      busy       <= (next_code != '0);
      timeout    <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (in_valid) begin
            code1 <= pair.first;
            code2 <= pair.second;
            err   <= pair.err;
            if (pair.first != '0) begin
              state <= GNT1;
            end
          end
        end
        GNT1: begin
          if (hold_end) begin
            cnt     <= '0;
            timeout <= !done;
            state   <= (code2 != '0) ? GNT2 : IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GNT2: begin
          if (hold_end) begin
            cnt     <= '0;
            timeout <= !done;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_grant_seq.sv
// tb/tb_dp_grant_seq.sv - directed and randomized pairs checked against a per-pair timeline model
// The model derives each cycle's outputs from the pair legality rules and the chosen done cycle.
module tb_dp_grant_seq;

  localparam int TMO = 16;
  localparam int NR  = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] first;
  logic [3:0] second;
  logic [11:0] grant;
  logic [3:0] grant_code;
  logic       done;
  logic       busy;
  logic       timeout;
  logic       err;

  int checks = 0;
  int passed = 0;

  dp_grant_seq #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .first      (first),
    .second     (second),
    .grant      (grant),
    .grant_code (grant_code),
    .done       (done),
    .busy       (busy),
    .timeout    (timeout),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] onehot(input int code);
    logic [11:0] one;
    one = 12'd1;
    return (code == 0) ? 12'd0 : (one << (code - 1));
  endfunction

  // Starts #1 after an edge in an idle cycle; returns #1 after the edge ending the idle cycle.
  task automatic run_pair(input int f, input int s, input int d1, input int d2, input bit hold_iv);
    int  f_eff, s_eff, h1, h2, len, code_exp;
    bit  e, to_exp, dn;
    e     = (f > NR) || (s > NR) || (s != 0 && s >= f);
    f_eff = (f > NR) ? 0 : f;
    s_eff = (f_eff == 0 || s > NR || (s != 0 && s >= f)) ? 0 : s;
    h1    = (f_eff != 0) ? ((d1 < TMO) ? d1 : TMO) : 0;
    h2    = (s_eff != 0) ? ((d2 < TMO) ? d2 : TMO) : 0;
    len   = h1 + h2 + 1;

    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    first    = 4'(f);
    second   = 4'(s);
    done     = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 1; c <= len; c++) begin
      code_exp = (c <= h1) ? f_eff : (c <= h1 + h2) ? s_eff : 0;
      to_exp   = (f_eff != 0 && d1 > TMO && c == h1 + 1) ||
                 (s_eff != 0 && d2 > TMO && c == h1 + h2 + 1);
      chk($sformatf("grant c%0d pair(%0d,%0d)", c, f, s), grant, onehot(code_exp));
      chk($sformatf("grant_code c%0d", c), grant_code, code_exp);
      chk($sformatf("busy c%0d", c), busy, code_exp != 0);
      chk($sformatf("in_ready c%0d", c), in_ready, code_exp == 0);
      chk($sformatf("timeout c%0d", c), timeout, to_exp);
      chk($sformatf("err c%0d", c), err, e && c == 1);
      dn = (c <= h1 && c == d1) || (c > h1 && c <= h1 + h2 && c - h1 == d2);
      if (c == len) begin
        dn       = 1'($urandom);
        in_valid = 1'b0;
      end else begin
        in_valid = hold_iv;
        first    = 4'($urandom_range(1, 12));
        second   = 4'($urandom_range(0, 11));
      end
      done = dn;
      @(posedge clk);
      #1;
    end
    done = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    first    = '0;
    second   = '0;
    done     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_grant_code", grant_code, 0);
    chk("reset_busy", busy, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_err", err, 0);
    chk("reset_in_ready", in_ready, 1);

    run_pair(12, 5, 3, 3, 0);
    run_pair(1, 0, 100, 0, 0);
    run_pair(7, 9, 2, 0, 0);
    run_pair(14, 3, 1, 1, 0);
    run_pair(0, 0, 1, 1, 0);
    run_pair(0, 3, 1, 1, 0);
    run_pair(9, 4, TMO, TMO, 0);
    run_pair(6, 2, 5, 4, 1);
    run_pair(3, 1, 100, 100, 1);

    // Reset in the middle of the first grant of (10, 4)
    in_valid = 1'b1;
    first    = 4'd10;
    second   = 4'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_reset_grant", grant, onehot(10));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_reset_grant", grant, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_timeout", timeout, 0);
    chk("mid_reset_err", err, 0);
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_grant", grant, 0);
    chk("post_reset_timeout", timeout, 0);
    run_pair(3, 2, 2, 5, 0);

    for (int i = 0; i < 60; i++) begin
      run_pair($urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(1, TMO + 2), $urandom_range(1, TMO + 2), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
